// File: rtl/cc_reorder_merge.sv
// cc_reorder_merge
//   Merges whole cache lines from the data array (hits) and bursts from the
//   memory AXI R channel (misses) into one in-order INCT R stream. The order
//   of hits and misses comes from a per-request order FIFO. Hit lines are
//   emitted critical-word-first: the word at the stored offset goes out first,
//   and the read pointer wraps around the line.
//
// Ports
//   clk, rst_n       clock, synchronous active-low reset
//   order_wren_i     push one order entry (order_wdata_i: 1 = hit, 0 = miss)
//   order_afull_o    order FIFO holds ORDER_DEPTH-1 or more entries
//   hit_wren_i       push one hit line; hit_wdata_i = {word offset, line}
//   hit_afull_o      hit FIFO holds HIT_DEPTH-1 or more lines
//   mem_r*           memory R channel (slave side; ready is driven here)
//   inct_r*          INCT R channel (registered data/last/valid)
//   err_o            sticky flags: [0] FIFO overflow, [1] burst-length mismatch
module cc_reorder_merge #(
    parameter int DATA_W      = 64,
    parameter int BEATS       = 8,
    parameter int OFS_W       = $clog2(BEATS),
    parameter int ORDER_DEPTH = 16,
    parameter int HIT_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          order_wren_i,
    input  logic                          order_wdata_i,
    output logic                          order_afull_o,
    input  logic                          hit_wren_i,
    input  logic [OFS_W+DATA_W*BEATS-1:0] hit_wdata_i,
    output logic                          hit_afull_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    input  logic                          mem_rlast_i,
    input  logic                          mem_rvalid_i,
    output logic                          mem_rready_o,
    output logic [DATA_W-1:0]             inct_rdata_o,
    output logic                          inct_rlast_o,
    output logic                          inct_rvalid_o,
    input  logic                          inct_rready_i,
    output logic [1:0]                    err_o
);

    localparam int LINE_W = DATA_W * BEATS;
    localparam int HIT_W  = OFS_W + LINE_W;
    localparam int OA_W   = $clog2(ORDER_DEPTH);
    localparam int HA_W   = $clog2(HIT_DEPTH);

    localparam logic [OA_W:0]      ORDER_FULL  = (OA_W+1)'(ORDER_DEPTH);
    localparam logic [OA_W:0]      ORDER_AFULL = (OA_W+1)'(ORDER_DEPTH - 1);
    localparam logic [OA_W:0]      ORDER_ONE   = (OA_W+1)'(1);
    localparam logic [HA_W:0]      HIT_FULL    = (HA_W+1)'(HIT_DEPTH);
    localparam logic [HA_W:0]      HIT_AFULL   = (HA_W+1)'(HIT_DEPTH - 1);
    localparam logic [OFS_W-1:0]   K_LAST      = OFS_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIT  = 2'd1,
        ST_MISS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Order FIFO (1 bit per request)
    // ------------------------------------------------------------------
    logic            order_mem_q [ORDER_DEPTH];
    logic [OA_W-1:0] order_wptr_q;
    logic [OA_W-1:0] order_rptr_q;
    logic [OA_W-1:0] order_rptr_nx;
    logic [OA_W:0]   order_cnt_q;
    logic            order_empty;
    logic            order_full;
    logic            order_push;
    logic            order_pop;
    logic            order_ovf;
    logic            order_head;
    logic            order_next;

    assign order_empty   = (order_cnt_q == '0);
    assign order_full    = (order_cnt_q == ORDER_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign order_push    = order_wren_i && (!order_full || order_pop);
    assign order_ovf     = order_wren_i && order_full && !order_pop;
    assign order_rptr_nx = order_rptr_q + 1'b1;
    assign order_head    = order_mem_q[order_rptr_q];
    assign order_next    = order_mem_q[order_rptr_nx];
    assign order_afull_o = (order_cnt_q >= ORDER_AFULL);

    always_ff @(posedge clk) begin
        if (order_push) begin
            order_mem_q[order_wptr_q] <= order_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            order_wptr_q <= '0;
            order_rptr_q <= '0;
            order_cnt_q  <= '0;
        end else begin
            if (order_push) begin
                order_wptr_q <= order_wptr_q + 1'b1;
            end
            if (order_pop) begin
                order_rptr_q <= order_rptr_nx;
            end
            case ({order_push, order_pop})
                2'b10:   order_cnt_q <= order_cnt_q + 1'b1;
                2'b01:   order_cnt_q <= order_cnt_q - 1'b1;
                default: order_cnt_q <= order_cnt_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hit-line FIFO ({offset, line} per entry)
    // ------------------------------------------------------------------
    logic [HIT_W-1:0] hit_mem_q [HIT_DEPTH];
    logic [HA_W-1:0]  hit_wptr_q;
    logic [HA_W-1:0]  hit_rptr_q;
    logic [HA_W:0]    hit_cnt_q;
    logic             hit_empty;
    logic             hit_full;
    logic             hit_push;
    logic             hit_pop;
    logic             hit_ovf;
    logic [HIT_W-1:0] hit_head;

    assign hit_empty   = (hit_cnt_q == '0);
    assign hit_full    = (hit_cnt_q == HIT_FULL);
    assign hit_push    = hit_wren_i && (!hit_full || hit_pop);
    assign hit_ovf     = hit_wren_i && hit_full && !hit_pop;
    assign hit_head    = hit_mem_q[hit_rptr_q];
    assign hit_afull_o = (hit_cnt_q >= HIT_AFULL);

    always_ff @(posedge clk) begin
        if (hit_push) begin
            hit_mem_q[hit_wptr_q] <= hit_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_wptr_q <= '0;
            hit_rptr_q <= '0;
            hit_cnt_q  <= '0;
        end else begin
            if (hit_push) begin
                hit_wptr_q <= hit_wptr_q + 1'b1;
            end
            if (hit_pop) begin
                hit_rptr_q <= hit_rptr_q + 1'b1;
            end
            case ({hit_push, hit_pop})
                2'b10:   hit_cnt_q <= hit_cnt_q + 1'b1;
                2'b01:   hit_cnt_q <= hit_cnt_q - 1'b1;
                default: hit_cnt_q <= hit_cnt_q;
            endcase
        end
    end

    // Split the head line into words; the offset add wraps modulo BEATS
    // because both operands are OFS_W bits wide.
    logic [DATA_W-1:0] hit_words [BEATS];
    logic [OFS_W-1:0]  hit_ofs;
    logic [OFS_W-1:0]  hit_widx;
    logic [DATA_W-1:0] hit_word;

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_word
            assign hit_words[gi] = hit_head[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Merge FSM and output register
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [OFS_W-1:0]  k_q;
    logic [DATA_W-1:0] inct_rdata_q;
    logic              inct_rlast_q;
    logic              inct_rvalid_q;
    logic [1:0]        err_q;

    logic   adv;
    logic   k_last;
    logic   hit_fire;
    logic   mem_fire;
    logic   burst_err;
    state_t chain_state;

    assign hit_ofs  = hit_head[HIT_W-1 -: OFS_W];
    assign hit_widx = hit_ofs + k_q;
    assign hit_word = hit_words[hit_widx];

    // The output register may take a new beat when it is empty or being drained.
    assign adv          = !inct_rvalid_q || inct_rready_i;
    assign k_last       = (k_q == K_LAST);
    assign hit_fire     = (state_q == ST_HIT) && !hit_empty && adv;
    assign mem_rready_o = (state_q == ST_MISS) && adv;
    assign mem_fire     = mem_rready_o && mem_rvalid_i;
    assign burst_err    = mem_fire && (mem_rlast_i != k_last);
    assign hit_pop      = hit_fire && k_last;
    assign order_pop    = hit_pop || (mem_fire && mem_rlast_i);

    // When a transaction ends and a second order entry is already stored,
    // jump straight to its state so consecutive transactions have no gap.
    assign chain_state = (order_cnt_q > ORDER_ONE) ? (order_next ? ST_HIT : ST_MISS) : ST_IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            inct_rdata_q  <= '0;
            inct_rlast_q  <= 1'b0;
            inct_rvalid_q <= 1'b0;
            err_q         <= 2'b00;
        end else begin
            err_q <= err_q | {burst_err, order_ovf || hit_ovf};
            case (state_q)
                ST_IDLE: begin
                    k_q <= '0;
                    if (adv) begin
                        inct_rvalid_q <= 1'b0;
                    end
                    if (!order_empty) begin
                        state_q <= order_head ? ST_HIT : ST_MISS;
                    end
                end
                ST_HIT: begin
                    if (hit_fire) begin
                        inct_rdata_q  <= hit_word;
                        inct_rlast_q  <= k_last;
                        inct_rvalid_q <= 1'b1;
                        if (k_last) begin
                            k_q     <= '0;
                            state_q <= chain_state;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end else if (adv) begin
                        inct_rvalid_q <= 1'b0;
                    end
                end
                ST_MISS: begin
                    if (mem_fire) begin
                        inct_rdata_q  <= mem_rdata_i;
                        inct_rlast_q  <= mem_rlast_i;
                        inct_rvalid_q <= 1'b1;
                        // Only mem rlast ends the burst, whatever the beat count says.
                        if (mem_rlast_i) begin
                            k_q     <= '0;
                            state_q <= chain_state;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end else if (adv) begin
                        inct_rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    k_q           <= '0;
                    inct_rvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign inct_rdata_o  = inct_rdata_q;
    assign inct_rlast_o  = inct_rlast_q;
    assign inct_rvalid_o = inct_rvalid_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cc_reorder_merge.sv
// Directed testbench for cc_reorder_merge (DATA_W=64, BEATS=8, depths 16/4).
module tb_cc_reorder_merge;

    localparam int DATA_W = 64;
    localparam int BEATS  = 8;
    localparam int OFS_W  = 3;
    localparam int HIT_W  = OFS_W + DATA_W * BEATS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              order_wren_i;
    logic              order_wdata_i;
    logic              order_afull_o;
    logic              hit_wren_i;
    logic [HIT_W-1:0]  hit_wdata_i;
    logic              hit_afull_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_rlast_i;
    logic              mem_rvalid_i;
    logic              mem_rready_o;
    logic [DATA_W-1:0] inct_rdata_o;
    logic              inct_rlast_o;
    logic              inct_rvalid_o;
    logic              inct_rready_i;
    logic [1:0]        err_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] cap_data [$];
    logic              cap_last [$];
    int                cap_cyc  [$];

    cc_reorder_merge #(
        .DATA_W(DATA_W), .BEATS(BEATS), .OFS_W(OFS_W),
        .ORDER_DEPTH(16), .HIT_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .order_wren_i(order_wren_i), .order_wdata_i(order_wdata_i), .order_afull_o(order_afull_o),
        .hit_wren_i(hit_wren_i), .hit_wdata_i(hit_wdata_i), .hit_afull_o(hit_afull_o),
        .mem_rdata_i(mem_rdata_i), .mem_rlast_i(mem_rlast_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rready_o(mem_rready_o),
        .inct_rdata_o(inct_rdata_o), .inct_rlast_o(inct_rlast_o), .inct_rvalid_o(inct_rvalid_o),
        .inct_rready_i(inct_rready_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every INCT handshake (valid && ready just before the rising edge).
    always @(negedge clk) begin
        if (rst_n && inct_rvalid_o && inct_rready_i) begin
            cap_data.push_back(inct_rdata_o);
            cap_last.push_back(inct_rlast_o);
            cap_cyc.push_back(cyc);
            $display("beat %0d: data=%h last=%0d cyc=%0d", cap_data.size() - 1, inct_rdata_o, inct_rlast_o, cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d beats, required finish", cap_data.size());
        $fatal(1);
    end

    // ---------------- stimulus helpers (caller sits at posedge+1) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_order(input logic is_hit);
        order_wren_i  = 1'b1;
        order_wdata_i = is_hit;
        step();
        order_wren_i  = 1'b0;
    endtask

    task automatic push_hit(input logic [OFS_W-1:0] ofs, input logic [DATA_W-1:0] base);
        logic [HIT_W-1:0] w;
        w = '0;
        for (int i = 0; i < BEATS; i++) w[i*DATA_W +: DATA_W] = base + DATA_W'(i);
        w[HIT_W-1 -: OFS_W] = ofs;
        hit_wren_i  = 1'b1;
        hit_wdata_i = w;
        step();
        hit_wren_i  = 1'b0;
    endtask

    // Presents n beats; valid is held until accepted, and with gaps=1 it drops
    // for one cycle after each accepted beat.
    task automatic mem_burst(input int n, input logic [DATA_W-1:0] base, input int last_idx, input bit gaps);
        int  i = 0;
        int  guard = 0;
        bit  v = 1'b1;
        while (i < n && guard < 400) begin
            mem_rvalid_i = v;
            mem_rdata_i  = base + DATA_W'(i);
            mem_rlast_i  = (i == last_idx);
            @(negedge clk);
            if (v && mem_rready_o) begin
                i++;
                v = !gaps;
            end else if (!v) begin
                v = 1'b1;
            end
            step();
            guard++;
        end
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        checks++;
        if (i != n) begin
            errors++;
            $display("FAIL mem_burst_accept: accepted %0d beats, required %0d", i, n);
        end
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (cap_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (cap_data.size() >= n) ok = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({inct_rvalid_o, inct_rlast_o, mem_rready_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: valid/last/mready=%b required 000", {inct_rvalid_o, inct_rlast_o, mem_rready_o});
        end
        checks++;
        if (inct_rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", inct_rdata_o);
        end
        checks++;
        if ({err_o, order_afull_o, hit_afull_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: err/oaf/haf=%b required 0000", {err_o, order_afull_o, hit_afull_o});
        end
    endtask

    task automatic test_hit_wrap();
        logic [DATA_W-1:0] exp_d [8] = '{64'h13, 64'h14, 64'h15, 64'h16, 64'h17, 64'h10, 64'h11, 64'h12};
        bit ok;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        inct_rready_i = 1'b1;
        push_order(1'b1);
        push_hit(3'd3, 64'h10);
        wait_caps(8, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hit_wrap_count: got %0d beats required 8", cap_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_d[i] || cap_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL hit_wrap_beat%0d: got %h/%0d required %h/%0d", i,
                         (i < cap_data.size()) ? cap_data[i] : 64'hx, (i < cap_last.size()) ? cap_last[i] : 1'bx, exp_d[i], (i == 7));
            end
        end
        repeat (3) step();
        checks++;
        if (inct_rvalid_o !== 1'b0 || mem_rready_o !== 1'b0 || cap_data.size() != 8) begin
            errors++;
            $display("FAIL hit_wrap_idle: valid=%0d mready=%0d beats=%0d required 0/0/8", inct_rvalid_o, mem_rready_o, cap_data.size());
        end
    endtask

    task automatic test_miss();
        bit ok;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        inct_rready_i = 1'b1;
        checks++;
        if (mem_rready_o !== 1'b0) begin
            errors++;
            $display("FAIL miss_mready_idle: got %0d required 0", mem_rready_o);
        end
        push_order(1'b0);
        mem_burst(8, 64'hA0, 7, 1'b1);
        wait_caps(8, 20, ok);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== 64'hA0 + 64'(i) || cap_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL miss_beat%0d: got %h required %h (beats %0d)", i,
                         (i < cap_data.size()) ? cap_data[i] : 64'hx, 64'hA0 + 64'(i), cap_data.size());
            end
        end
        repeat (2) step();
        checks++;
        if (mem_rready_o !== 1'b0 || err_o !== 2'b00) begin
            errors++;
            $display("FAIL miss_after: mready=%0d err=%b required 0/00", mem_rready_o, err_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_d [24];
        bit ok;
        for (int i = 0; i < 8; i++) exp_d[i] = 64'h20 + 64'(i);
        for (int i = 0; i < 8; i++) exp_d[8 + i] = 64'hB0 + 64'(i);
        for (int i = 0; i < 8; i++) exp_d[16 + i] = 64'h30 + 64'((i + 5) % 8);
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        inct_rready_i = 1'b1;
        push_order(1'b1);
        push_order(1'b0);
        push_order(1'b1);
        fork
            mem_burst(8, 64'hB0, 7, 1'b0);
            begin
                step();
                push_hit(3'd0, 64'h20);
                push_hit(3'd5, 64'h30);
            end
        join
        wait_caps(24, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_count: got %0d beats required 24", cap_data.size());
        end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_d[i] || cap_last[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL b2b_beat%0d: got %h required %h", i, (i < cap_data.size()) ? cap_data[i] : 64'hx, exp_d[i]);
            end
        end
        if (ok) begin
            checks++;
            if (cap_cyc[23] - cap_cyc[0] != 23) begin
                errors++;
                $display("FAIL b2b_gapless: span %0d cycles required 23", cap_cyc[23] - cap_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] exp_d [16];
        bit ok;
        for (int i = 0; i < 8; i++) exp_d[i] = 64'h40 + 64'((i + 6) % 8);
        for (int i = 0; i < 8; i++) exp_d[8 + i] = 64'hC0 + 64'(i);
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        push_order(1'b1);
        push_order(1'b0);
        push_hit(3'd6, 64'h40);
        fork
            mem_burst(8, 64'hC0, 7, 1'b1);
            begin
                bit                pv = 1'b0;
                bit                pr = 1'b0;
                logic [DATA_W-1:0] pd = '0;
                logic              pl = 1'b0;
                int                guard = 0;
                while (cap_data.size() < 16 && guard < 400) begin
                    inct_rready_i = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (pv && !pr) begin
                        checks++;
                        if (inct_rvalid_o !== 1'b1 || inct_rdata_o !== pd || inct_rlast_o !== pl) begin
                            errors++;
                            $display("FAIL bp_hold: got %0d/%h/%0d required 1/%h/%0d", inct_rvalid_o, inct_rdata_o, inct_rlast_o, pd, pl);
                        end
                    end
                    if (inct_rvalid_o && !inct_rready_i) begin
                        checks++;
                        if (mem_rready_o !== 1'b0) begin
                            errors++;
                            $display("FAIL bp_mready: got %0d required 0 while stalled", mem_rready_o);
                        end
                    end
                    pv = inct_rvalid_o; pr = inct_rready_i; pd = inct_rdata_o; pl = inct_rlast_o;
                    step();
                    guard++;
                end
                inct_rready_i = 1'b1;
            end
        join
        wait_caps(16, 10, ok);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== exp_d[i] || cap_last[i] !== (i % 8 == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h required %h", i, (i < cap_data.size()) ? cap_data[i] : 64'hx, exp_d[i]);
            end
        end
        repeat (3) step();
        checks++;
        if (cap_data.size() != 16) begin
            errors++;
            $display("FAIL bp_total: got %0d beats required 16", cap_data.size());
        end
    endtask

    task automatic test_burst_err();
        bit ok;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        inct_rready_i = 1'b1;
        push_order(1'b0);
        push_order(1'b1);
        push_hit(3'd0, 64'h50);
        mem_burst(6, 64'hD0, 5, 1'b0);
        wait_caps(14, 30, ok);
        for (int i = 0; i < 14; i++) begin
            logic [DATA_W-1:0] e;
            e = (i < 6) ? 64'hD0 + 64'(i) : 64'h50 + 64'(i - 6);
            checks++;
            if (i >= cap_data.size() || cap_data[i] !== e || cap_last[i] !== (i == 5 || i == 13)) begin
                errors++;
                $display("FAIL berr_beat%0d: got %h required %h", i, (i < cap_data.size()) ? cap_data[i] : 64'hx, e);
            end
        end
        repeat (4) step();
        checks++;
        if (err_o !== 2'b10) begin
            errors++;
            $display("FAIL berr_flag: got %b required 10", err_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        push_hit(3'd0, 64'h0);
        push_hit(3'd0, 64'h8);
        checks++;
        if (hit_afull_o !== 1'b0) begin
            errors++;
            $display("FAIL hit_afull_2: got %0d required 0", hit_afull_o);
        end
        push_hit(3'd0, 64'h10);
        checks++;
        if (hit_afull_o !== 1'b1) begin
            errors++;
            $display("FAIL hit_afull_3: got %0d required 1", hit_afull_o);
        end
        for (int n = 1; n <= 17; n++) begin
            push_order(1'b0);
            if (n == 14) begin
                checks++;
                if (order_afull_o !== 1'b0) begin
                    errors++;
                    $display("FAIL order_afull_14: got %0d required 0", order_afull_o);
                end
            end
            if (n == 15) begin
                checks++;
                if (order_afull_o !== 1'b1) begin
                    errors++;
                    $display("FAIL order_afull_15: got %0d required 1", order_afull_o);
                end
            end
            if (n == 16) begin
                checks++;
                if (err_o !== 2'b00) begin
                    errors++;
                    $display("FAIL order_full_noerr: got %b required 00", err_o);
                end
            end
        end
        checks++;
        if (err_o !== 2'b01) begin
            errors++;
            $display("FAIL order_ovf: got %b required 01", err_o);
        end
    endtask

    task automatic test_reset_mid_hit();
        bit ok;
        do_reset();
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        inct_rready_i = 1'b1;
        push_order(1'b1);
        push_hit(3'd2, 64'h70);
        wait_caps(3, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_mid_start: got %0d beats required 3", cap_data.size());
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({inct_rvalid_o, inct_rlast_o, mem_rready_o, err_o, order_afull_o, hit_afull_o} !== 7'b0 || inct_rdata_o !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: valid=%0d last=%0d mready=%0d err=%b data=%h required all 0",
                     inct_rvalid_o, inct_rlast_o, mem_rready_o, err_o, inct_rdata_o);
        end
        rst_n = 1'b1;
        cap_data.delete(); cap_last.delete(); cap_cyc.delete();
        repeat (20) step();
        checks++;
        if (cap_data.size() != 0 || inct_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_discard: got %0d beats valid=%0d required 0/0", cap_data.size(), inct_rvalid_o);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        order_wren_i  = 1'b0;
        order_wdata_i = 1'b0;
        hit_wren_i    = 1'b0;
        hit_wdata_i   = '0;
        mem_rdata_i   = '0;
        mem_rlast_i   = 1'b0;
        mem_rvalid_i  = 1'b0;
        inct_rready_i = 1'b1;
        step();
        test_reset();
        test_hit_wrap();
        test_miss();
        test_back_to_back();
        test_backpressure();
        test_burst_err();
        test_overflow();
        test_reset_mid_hit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_reorder_merge.md
Name: cc_reorder_merge

Overview:
- Parametrised successor of the cache controller's read-data reorder stage.
- Merges hit lines (whole cache lines from the data array) and miss lines (bursts from the memory AXI R channel) into one in-order INCT R-channel stream, using a per-request hit/miss order FIFO.
- Adds configurable width, depth and beats per line, and critical-word-first wrap of hit lines.
- Adds full AXI backpressure on the output, zero-bubble back-to-back transfers, and sticky protocol-error flags.

Parameters:
- DATA_W, 64, beat width in bits.
- BEATS, 8, beats per cache line; power of two, at least 2.
- OFS_W, $clog2(BEATS), derived; word-offset width.
- ORDER_DEPTH, 16, order FIFO entries; power of two.
- HIT_DEPTH, 4, hit-line FIFO entries; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- order_wren_i  in  1  push one order entry
- order_wdata_i  in  1  1 = hit, 0 = miss
- order_afull_o  out  1  order count >= ORDER_DEPTH-1
- hit_wren_i  in  1  push one hit line
- hit_wdata_i  in  OFS_W+DATA_W*BEATS  {word offset, line}; word i = bits [i*DATA_W +: DATA_W]
- hit_afull_o  out  1  hit count >= HIT_DEPTH-1
- mem_rdata_i  in  DATA_W  memory R data
- mem_rlast_i  in  1  memory R last
- mem_rvalid_i  in  1  memory R valid
- mem_rready_o  out  1  memory R ready
- inct_rdata_o  out  DATA_W  INCT R data (registered)
- inct_rlast_o  out  1  INCT R last (registered)
- inct_rvalid_o  out  1  INCT R valid (registered)
- inct_rready_i  in  1  INCT R ready
- err_o  out  2  sticky; [0] = FIFO overflow, [1] = memory burst-length mismatch

Behaviour:
- Reset (clk is the clock; rst_n is a synchronous, active-low reset): FIFOs empty; state IDLE; beat counter 0; all outputs 0, including err_o, mem_rready_o and inct_rvalid_o.
- FIFO writes are visible at the read head the cycle after the write. Writes while full are dropped and set err_o[0].
- Output register advances when adv = !inct_rvalid_o || inct_rready_i. It holds data, last and valid stable while inct_rvalid_o=1 and inct_rready_i=0.
- State IDLE: if the order FIFO is non-empty, go to HIT when head=1, else MISS. Counter k=0.
- State HIT:
  - While the hit FIFO is empty, stall; no output.
  - Otherwise, when adv: load word (ofs+k) mod BEATS of the head line; rlast=(k==BEATS-1); k++.
  - On the last beat: pop the hit and order FIFOs, k=0.
- State MISS:
  - mem_rready_o = adv (combinational); accept a beat when mem_rvalid_i && mem_rready_o.
  - Data passes through unchanged; inct rlast = mem_rlast_i.
  - On mem_rlast_i: pop the order FIFO and set k=0.
  - If mem_rlast_i arrives with k!=BEATS-1, or k==BEATS-1 without mem_rlast_i, set err_o[1]. The burst still terminates on mem_rlast_i only.
- mem_rready_o = 0 in every state other than MISS.
- At a last beat with the next order entry already visible, select the next state directly (HIT/MISS, not IDLE). Result: zero idle cycles between consecutive transactions when sources are ready.
- Latency: first output beat is registered 1 cycle after the source beat is available (order head valid and source ready).
- Throughput: 1 beat/cycle with inct_rready_i=1.
- Simultaneous push and pop on a full FIFO is legal: the count is unchanged and no overflow is flagged.
- afull outputs are derived from registered counts.
- Reset mid-burst: abort immediately; all state returns to reset values; partial data is discarded.

Test Plan:
- Hit, offset 3, line words = 0x10..0x17, inct_rready=1 -> 17,... no; beats emitted in order 0x13,0x14,0x15,0x16,0x17,0x10,0x11,0x12; rlast on 0x12; order FIFO empty afterwards.
- Miss, mem supplies 8 beats 0xA0..0xA7 with rlast on the 8th, rvalid toggling -> identical sequence on inct; mem_rready_o high only in MISS; err_o=0.
- Order H,M,H with miss data arriving before the hit lines -> output H line, then miss burst, then H line, in that order; no idle cycles between transactions once the data is available; 24 beats total.
- inct_rready pseudo-random at 50% during a hit then a miss -> no beat lost or duplicated; data and last stable while stalled; mem_rready_o=0 on stalled cycles.
- mem_rlast on beat 5 of a miss -> err_o=2'b10 set and held; next order entry serviced normally.
- Push 17 order entries with no reads -> order_afull_o at count 15; 17th write dropped, err_o[0]=1. Assert rst_n=0 mid-hit -> all outputs 0 next cycle.
